mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 124 ++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default geometry for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
  typedef enum logic [1:0] {READ, WRITE, ILLEGAL} mem_op_t;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_1000;
  localparam int          DEF_DEPTH_WORDS = 4096;
  localparam int          DEF_LATENCY     = 2;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, combinational read of the same index.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for a simple core bus; storage lives in mem_array.
// Define MEM_ERR_EN to add the mem_err port and accept read+write as an erroring transaction.
module mem_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int          LATENCY     = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
`ifdef MEM_ERR_EN
  ,
  output logic        mem_err
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_state_t    state;
  mem_op_t       cur_op, lat_op, sel_op;
  logic [3:0]    cnt;
  logic [31:0]   offset, arr_rdata, lat_wdata;
  logic [AW-1:0] cur_idx, lat_idx, arr_idx;
  logic          cur_hit, lat_hit, sel_hit;
  logic          accept, enter_resp, arr_we;
  logic [1:0]    unused_lsb;

  assign offset     = mem_addr - BASE_ADDR;
  assign unused_lsb = offset[1:0];
  assign cur_idx    = offset[AW+1:2];
  assign cur_hit    = (mem_addr >= BASE_ADDR) && ({2'b00, offset[31:2]} < 32'(DEPTH_WORDS));

  always_comb begin
    cur_op = READ;
    if (mem_read && mem_write) cur_op = ILLEGAL;
    else if (mem_write)        cur_op = WRITE;
  end

`ifdef MEM_ERR_EN
  assign accept = (state == IDLE) && (mem_read || mem_write);
`else
  assign accept = (state == IDLE) && (mem_read ^ mem_write);
`endif

  // With LATENCY=1 the response is loaded straight from IDLE, so the live
  // request (not the latched copy) selects the array word and result.
  assign sel_op     = (state == IDLE) ? cur_op : lat_op;
  assign sel_hit    = (state == IDLE) ? (cur_hit && cur_op != ILLEGAL) : lat_hit;
  assign enter_resp = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
  assign arr_idx    = (state == IDLE) ? cur_idx : lat_idx;
  // Gate on rst_n so a reset at the end of RESP aborts the commit.
  assign arr_we     = rst_n && (state == RESP) && (lat_op == WRITE) && lat_hit;

`ifdef MEM_ERR_EN
  logic cur_err, lat_err, sel_err;
  assign cur_err = !cur_hit || (mem_addr[1:0] != 2'b00) || (cur_op == ILLEGAL);
  assign sel_err = (state == IDLE) ? cur_err : lat_err;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      lat_op    <= READ;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_hit   <= 1'b0;
`ifdef MEM_ERR_EN
      mem_err   <= 1'b0;
      lat_err   <= 1'b0;
`endif
    end else begin
      mem_resp <= 1'b0;
`ifdef MEM_ERR_EN
      mem_err  <= 1'b0;
`endif
      case (state)
        IDLE: if (accept) begin
          lat_op    <= cur_op;
          lat_idx   <= cur_idx;
          lat_wdata <= mem_wdata;
          lat_hit   <= cur_hit && (cur_op != ILLEGAL);
`ifdef MEM_ERR_EN
          lat_err   <= cur_err;
`endif
          cnt       <= 4'(LATENCY - 1);
          state     <= (LATENCY == 1) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        mem_resp <= 1'b1;
        if (sel_op == READ)         mem_rdata <= sel_hit ? arr_rdata : '0;
        else if (sel_op == ILLEGAL) mem_rdata <= '0;
`ifdef MEM_ERR_EN
        mem_err <= sel_err;
`endif
      end
    end
  end

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (lat_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: LATENCY=2 instance (dut) and LATENCY=1 instance (dut1) on one clock.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
  logic        read0, write0, resp0, read1, write1, resp1, err0, err1;
  int          n_chk = 0;
  int          n_fail = 0;

  mem_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr0), .mem_wdata(wdata0),
    .mem_read(read0), .mem_write(write0), .mem_rdata(rdata0), .mem_resp(resp0)
`ifdef MEM_ERR_EN
    , .mem_err(err0)
`endif
  );

  mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_read(read1), .mem_write(write1), .mem_rdata(rdata1), .mem_resp(resp1)
`ifdef MEM_ERR_EN
    , .mem_err(err1)
`endif
  );

`ifndef MEM_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request in an IDLE cycle (cycle 0), hold it until mem_resp,
  // drop it, and return to the following IDLE cycle.
  task automatic txn(input bit u1, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, output int cyc, output logic [31:0] q, output logic e);
    cyc = -1; q = 'x; e = 'x;
    if (u1) begin read1 = rd; write1 = wr; addr1 = a; wdata1 = d; end
    else    begin read0 = rd; write0 = wr; addr0 = a; wdata0 = d; end
    for (int c = 0; c < 20; c++) begin
      if (u1 ? resp1 : resp0) begin
        cyc = c; q = u1 ? rdata1 : rdata0; e = u1 ? err1 : err0;
        break;
      end
      step();
    end
    if (u1) begin read1 = 1'b0; write1 = 1'b0; end
    else    begin read0 = 1'b0; write0 = 1'b0; end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    read0 = 0; write0 = 0; addr0 = 0; wdata0 = 0;
    read1 = 0; write1 = 0; addr1 = 0; wdata1 = 0;
    step(); step();
    n_chk++; if (resp0 !== 1'b0) begin n_fail++; $display("FAIL reset_resp0 got %b want 0", resp0); end
    n_chk++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0 got %h want 0", rdata0); end
    n_chk++; if (resp1 !== 1'b0) begin n_fail++; $display("FAIL reset_resp1 got %b want 0", resp1); end
    n_chk++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err0 got %b want 0", err0); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    int cyc, first, pulses;
    logic [31:0] q;
    logic e;
    addr0 = 32'h1004; wdata0 = 32'hDEADBEEF; write0 = 1'b1;
    first = -1; pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp0) begin pulses++; if (first < 0) first = c; write0 = 1'b0; end
      step();
    end
    n_chk++; if (first !== 2) begin n_fail++; $display("FAIL wr_latency got %0d want 2", first); end
    n_chk++; if (pulses !== 1) begin n_fail++; $display("FAIL wr_pulses got %0d want 1", pulses); end
    txn(0, 1, 0, 32'h1004, 0, cyc, q, e);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL rd_latency got %0d want 2", cyc); end
    n_chk++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", q); end
    txn(0, 0, 1, 32'h100C, 32'hA5A5_0001, cyc, q, e);
    txn(0, 1, 0, 32'h100C, 0, cyc, q, e);
    n_chk++; if (q !== 32'hA5A5_0001) begin n_fail++; $display("FAIL raw_data got %h want a5a50001", q); end
  endtask

  task automatic test_latency1();
    int cyc, r1, r2, pulses;
    logic [31:0] q, d1, d2;
    logic e;
    txn(1, 0, 1, 32'h1000, 32'h0000_0013, cyc, q, e);
    n_chk++; if (cyc !== 1) begin n_fail++; $display("FAIL l1_wr_latency got %0d want 1", cyc); end
    addr1 = 32'h1000; read1 = 1'b1;
    r1 = -1; r2 = -1; pulses = 0; d1 = 'x; d2 = 'x;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) read1 = 1'b0;
      if (resp1) begin
        pulses++;
        if (r1 < 0) begin r1 = c; d1 = rdata1; end
        else if (r2 < 0) begin r2 = c; d2 = rdata1; end
      end
      step();
    end
    n_chk++; if (r1 !== 1) begin n_fail++; $display("FAIL l1_first got %0d want 1", r1); end
    n_chk++; if (d1 !== 32'h13) begin n_fail++; $display("FAIL l1_data got %h want 00000013", d1); end
    n_chk++; if (r2 !== 3) begin n_fail++; $display("FAIL l1_second got %0d want 3", r2); end
    n_chk++; if (d2 !== 32'h13) begin n_fail++; $display("FAIL l1_data2 got %h want 00000013", d2); end
    n_chk++; if (pulses !== 2) begin n_fail++; $display("FAIL l1_pulses got %0d want 2", pulses); end
  endtask

  task automatic test_out_of_range();
    int cyc;
    logic [31:0] q;
    logic e;
    txn(0, 0, 1, 32'h1000, 32'h0A0A_0A0A, cyc, q, e);
    txn(0, 0, 1, 32'h4FFC, 32'h0B0B_0B0B, cyc, q, e);
    txn(0, 1, 0, 32'h1004, 0, cyc, q, e);
    txn(0, 1, 0, 32'h0FFC, 0, cyc, q, e);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL oor_low_resp got %0d want 2", cyc); end
    n_chk++; if (q !== 32'h0) begin n_fail++; $display("FAIL oor_low_data got %h want 0", q); end
`ifdef MEM_ERR_EN
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_low_err got %b want 1", e); end
`endif
    txn(0, 1, 0, 32'h1004, 0, cyc, q, e);
    txn(0, 1, 0, 32'h5000, 0, cyc, q, e);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL oor_high_resp got %0d want 2", cyc); end
    n_chk++; if (q !== 32'h0) begin n_fail++; $display("FAIL oor_high_data got %h want 0", q); end
    txn(0, 0, 1, 32'h5000, 32'hBAD0_0001, cyc, q, e);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL oor_wr_resp got %0d want 2", cyc); end
    txn(0, 0, 1, 32'h0FFC, 32'hBAD0_0002, cyc, q, e);
    txn(0, 1, 0, 32'h1000, 0, cyc, q, e);
    n_chk++; if (q !== 32'h0A0A_0A0A) begin n_fail++; $display("FAIL oor_wr_word0 got %h want 0a0a0a0a", q); end
    txn(0, 1, 0, 32'h4FFC, 0, cyc, q, e);
    n_chk++; if (q !== 32'h0B0B_0B0B) begin n_fail++; $display("FAIL oor_wr_last got %h want 0b0b0b0b", q); end
  endtask

  task automatic test_reset_abort();
    int cyc, pulses;
    logic [31:0] q;
    logic e;
    txn(0, 0, 1, 32'h1008, 32'h1111_1111, cyc, q, e);
    addr0 = 32'h1008; wdata0 = 32'h2222_2222; write0 = 1'b1;
    step();
    rst_n = 1'b0; write0 = 1'b0;
    step();
    n_chk++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL abort_rdata got %h want 0", rdata0); end
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin if (resp0) pulses++; step(); end
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_wait_resp got %0d pulses want 0", pulses); end
    // Reset landing on the edge that ends RESP must still cancel the write.
    addr0 = 32'h1008; wdata0 = 32'h3333_3333; write0 = 1'b1;
    step(); step();
    n_chk++; if (resp0 !== 1'b1) begin n_fail++; $display("FAIL abort_resp_seen got %b want 1", resp0); end
    rst_n = 1'b0; write0 = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    txn(0, 1, 0, 32'h1008, 0, cyc, q, e);
    n_chk++; if (q !== 32'h1111_1111) begin n_fail++; $display("FAIL abort_data got %h want 11111111", q); end
  endtask

  task automatic test_illegal();
`ifdef MEM_ERR_EN
    int cyc;
    logic [31:0] q;
    logic e;
    txn(0, 1, 1, 32'h1004, 32'h7777_7777, cyc, q, e);
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL illegal_resp got %0d want 2", cyc); end
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b want 1", e); end
    n_chk++; if (q !== 32'h0) begin n_fail++; $display("FAIL illegal_data got %h want 0", q); end
`else
    int pulses;
    addr0 = 32'h1004; wdata0 = 32'h7777_7777; read0 = 1'b1; write0 = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin if (resp0) pulses++; step(); end
    read0 = 1'b0; write0 = 1'b0;
    step();
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL illegal_pulses got %0d want 0", pulses); end
`endif
  endtask

  task automatic test_addr_change();
    int cyc;
    logic [31:0] q;
    logic e;
    txn(0, 0, 1, 32'h2000, 32'h55AA_55AA, cyc, q, e);
    txn(0, 1, 0, 32'h1004, 0, cyc, q, e);
    addr0 = 32'h1004; read0 = 1'b1;
    step();
    read0 = 1'b0; addr0 = 32'h2000;
    cyc = -1; q = 'x;
    for (int c = 1; c < 8; c++) begin
      if (resp0) begin cyc = c; q = rdata0; break; end
      step();
    end
    step();
    n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL change_resp got %0d want 2", cyc); end
    n_chk++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL change_data got %h want deadbeef", q); end
  endtask

  task automatic test_misaligned();
    int cyc;
    logic [31:0] q;
    logic e;
    txn(0, 1, 0, 32'h2000, 0, cyc, q, e);
    txn(0, 1, 0, 32'h1006, 0, cyc, q, e);
    n_chk++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL misalign_data got %h want deadbeef", q); end
`ifdef MEM_ERR_EN
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL misalign_err got %b want 1", e); end
`endif
  endtask

  task automatic test_back_to_back();
    int r1, r2, pulses;
    addr0 = 32'h1004; read0 = 1'b1;
    r1 = -1; r2 = -1; pulses = 0;
    for (int c = 0; c < 9; c++) begin
      if (c == 6) read0 = 1'b0;
      if (resp0) begin
        pulses++;
        if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
      end
      step();
    end
    n_chk++; if (r1 !== 2) begin n_fail++; $display("FAIL b2b_first got %0d want 2", r1); end
    n_chk++; if (r2 !== 5) begin n_fail++; $display("FAIL b2b_second got %0d want 5", r2); end
    n_chk++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency1();
    test_out_of_range();
    test_reset_abort();
    test_illegal();
    test_addr_change();
    test_misaligned();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
